// File: rtl/spi_pkg.sv
// spi_pkg: shared field widths and frame-state type for the SPI frame decoder.
package spi_pkg;
    localparam int SPI_ADDR_W = 7;
    localparam int SPI_DATA_W = 8;
    typedef enum logic {SPI_CMD, SPI_DATA} spi_state_t;
endpackage

// File: rtl/spi_shift_in.sv
// spi_shift_in: MSB-first shift register and bit counter; flags the edge that completes each byte.
module spi_shift_in import spi_pkg::*; #(
    parameter int DATA_W = SPI_DATA_W
) (
    input  logic              spi_clk,
    input  logic              full_rstn,
    input  logic              pico,
    output logic [DATA_W-1:0] data_byte,
    output logic              byte_done
);
    localparam int CNT_W = $clog2(DATA_W);
    logic [DATA_W-2:0] shift_q;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    // The completed byte includes the bit arriving on this edge, so there is no extra latency.
    assign data_byte = {shift_q, pico};
    assign byte_done = bit_cnt_q == CNT_W'(DATA_W - 1);
    assign bit_cnt_d = byte_done ? '0 : bit_cnt_q + 1'b1;
    always_ff @(posedge spi_clk or negedge full_rstn) begin
        if (!full_rstn) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            shift_q   <= data_byte[DATA_W-2:0];
            bit_cnt_q <= bit_cnt_d;
        end
    end
endmodule

// File: rtl/spi_frame_decoder.sv
// spi_frame_decoder: splits an SPI frame into a command byte and data bytes for the register file.
// Define SPI_ADDR_AUTOINC_EN to advance addr after every data byte.
module spi_frame_decoder import spi_pkg::*; #(
    parameter int ADDR_W    = SPI_ADDR_W,
    parameter int DATA_W    = SPI_DATA_W,
    parameter int MAX_BURST = 16
) (
    input  logic                           spi_clk,
    input  logic                           full_rstn,
    input  logic                           pico,
    output logic [ADDR_W-1:0]              addr,
    output logic                           is_write,
    output logic                           cmd_valid,
    output logic [DATA_W-1:0]              wdata,
    output logic                           wdata_valid,
    output logic [$clog2(MAX_BURST+1)-1:0] burst_cnt,
    output logic                           burst_ovf
);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    spi_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              is_write_q, is_write_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wdata_valid_q, wdata_valid_d;
    logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
    logic              burst_ovf_q, burst_ovf_d;
    logic [DATA_W-1:0] data_byte;
    logic              byte_done;
    logic              at_max;

    spi_shift_in #(.DATA_W(DATA_W)) u_shift (
        .spi_clk   (spi_clk),
        .full_rstn (full_rstn),
        .pico      (pico),
        .data_byte (data_byte),
        .byte_done (byte_done)
    );

    assign at_max = burst_cnt_q == CNT_W'(MAX_BURST);

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        is_write_d    = is_write_q;
        cmd_valid_d   = cmd_valid_q;
        wdata_d       = wdata_q;
        wdata_valid_d = 1'b0;
        burst_cnt_d   = burst_cnt_q;
        burst_ovf_d   = burst_ovf_q;
        if (byte_done && state_q == SPI_CMD) begin
            {is_write_d, addr_d} = data_byte;
            cmd_valid_d          = 1'b1;
            state_d              = SPI_DATA;
        end else if (byte_done) begin
            wdata_d       = data_byte;
            wdata_valid_d = is_write_q;
            burst_cnt_d   = at_max ? burst_cnt_q : burst_cnt_q + 1'b1;
            burst_ovf_d   = burst_ovf_q | at_max;
`ifdef SPI_ADDR_AUTOINC_EN
            addr_d        = addr_q + 1'b1;
`else
            addr_d        = addr_q;
`endif
        end
    end

    // DATA has no exit; the frame ends only when csb pulls full_rstn low.
    always_ff @(posedge spi_clk or negedge full_rstn) begin
        if (!full_rstn) begin
            state_q       <= SPI_CMD;
            addr_q        <= '0;
            is_write_q    <= 1'b0;
            cmd_valid_q   <= 1'b0;
            wdata_q       <= '0;
            wdata_valid_q <= 1'b0;
            burst_cnt_q   <= '0;
            burst_ovf_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            is_write_q    <= is_write_d;
            cmd_valid_q   <= cmd_valid_d;
            wdata_q       <= wdata_d;
            wdata_valid_q <= wdata_valid_d;
            burst_cnt_q   <= burst_cnt_d;
            burst_ovf_q   <= burst_ovf_d;
        end
    end

    assign addr        = addr_q;
    assign is_write    = is_write_q;
    assign cmd_valid   = cmd_valid_q;
    assign wdata       = wdata_q;
    assign wdata_valid = wdata_valid_q;
    assign burst_cnt   = burst_cnt_q;
    assign burst_ovf   = burst_ovf_q;
endmodule
